// File: rtl/ex_mdu_stage_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The master side is the pipeline; the slave side is ex_mdu_stage.
interface ex_mdu_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            mdop;
    logic [DATA_WIDTH-1:0] opr_a;
    logic [DATA_WIDTH-1:0] opr_b;
    logic [RD_WIDTH-1:0]   rd_in;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic [RD_WIDTH-1:0]   rd_out;
    logic                  busy;

    modport master (
        output in_valid, mdop, opr_a, opr_b, rd_in, flush, out_ready,
        input  in_ready, out_valid, result, rd_out, busy
    );

    modport slave (
        input  in_valid, mdop, opr_a, opr_b, rd_in, flush, out_ready,
        output in_ready, out_valid, result, rd_out, busy
    );
endinterface

// File: rtl/ex_mdu_stage.sv
// Iterative RV32M/RV64M multiply/divide unit (shift-add multiply, restoring divide).
// Define PAK_RV_MDU_FAST_MUL_EN to replace the iterative multiply with a one-cycle multiplier.
module ex_mdu_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    ex_mdu_stage_if.slave   mdu
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t              state_reg, state_next;
    logic [1:0]          op_reg;
    logic                neg_reg;
    logic [W-1:0]        mcand_reg;
    logic [2*W-1:0]      prod_reg;
    logic [CW-1:0]       cnt_reg;
    logic [W-1:0]        result_reg;
    logic [RD_WIDTH-1:0] rd_out_reg;

    // Request decode
    logic         a_signed, b_signed, sa, sb, neg_in;
    logic [W-1:0] abs_a, abs_b;
    logic         div_zero, div_ovf, special;
    logic [W-1:0] special_res;

    assign a_signed = (mdu.mdop == 3'd1) || (mdu.mdop == 3'd2) ||
                      (mdu.mdop == 3'd4) || (mdu.mdop == 3'd6);
    assign b_signed = (mdu.mdop == 3'd1) || (mdu.mdop == 3'd4) || (mdu.mdop == 3'd6);
    assign sa       = a_signed & mdu.opr_a[W-1];
    assign sb       = b_signed & mdu.opr_b[W-1];
    assign abs_a    = sa ? (W'(0) - mdu.opr_a) : mdu.opr_a;
    assign abs_b    = sb ? (W'(0) - mdu.opr_b) : mdu.opr_b;
    // Remainder follows the dividend sign; everything else takes the product/quotient sign.
    assign neg_in   = (mdu.mdop == 3'd6) ? sa : (sa ^ sb);

    assign div_zero = mdu.mdop[2] && (mdu.opr_b == '0);
    assign div_ovf  = mdu.mdop[2] && !mdu.mdop[0] &&
                      (mdu.opr_a == MOST_NEG) && (mdu.opr_b == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = mdu.mdop[1] ? mdu.opr_a : '1;
        else
            special_res = mdu.mdop[1] ? '0 : MOST_NEG;
    end

`ifdef PAK_RV_MDU_FAST_MUL_EN
    logic [2*W-1:0] fast_a, fast_b, fast_prod;
    logic [W-1:0]   fast_res;

    // Sign-extended operands make the truncated product exact for all signedness mixes.
    assign fast_a    = {{W{sa}}, mdu.opr_a};
    assign fast_b    = {{W{sb}}, mdu.opr_b};
    assign fast_prod = fast_a * fast_b;
    assign fast_res  = (mdu.mdop[1:0] == 2'd0) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
`endif

    // One iteration of each datapath
    logic           last_iter;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_step, mul_full;
    logic [W-1:0]   mul_res;
    logic [W:0]     div_shift, div_diff;
    logic           div_ge;
    logic [2*W-1:0] div_step;
    logic [W-1:0]   div_raw, div_res;

    assign last_iter = (cnt_reg == CW'(W - 1));

    assign mul_sum  = {1'b0, prod_reg[2*W-1:W]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
    assign mul_step = {mul_sum, prod_reg[W-1:1]};
    assign mul_full = neg_reg ? ((2*W)'(0) - mul_step) : mul_step;
    assign mul_res  = (op_reg == 2'd0) ? mul_full[W-1:0] : mul_full[2*W-1:W];

    // Upper half holds the partial remainder, lower half shifts dividend out and quotient in.
    assign div_shift = prod_reg[2*W-1:W-1];
    assign div_diff  = div_shift - {1'b0, mcand_reg};
    assign div_ge    = !div_diff[W];
    assign div_step  = {div_ge ? div_diff[W-1:0] : div_shift[W-1:0], prod_reg[W-2:0], div_ge};
    assign div_raw   = op_reg[1] ? div_step[2*W-1:W] : div_step[W-1:0];
    assign div_res   = neg_reg ? (W'(0) - div_raw) : div_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (mdu.flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mdu.in_valid) begin
                        if (special)
                            state_next = DONE;
                        else if (mdu.mdop[2])
                            state_next = DIV;
                        else
`ifdef PAK_RV_MDU_FAST_MUL_EN
                            state_next = DONE;
`else
                            state_next = MUL;
`endif
                    end
                end
                MUL:     if (last_iter) state_next = DONE;
                DIV:     if (last_iter) state_next = DONE;
                DONE:    if (mdu.out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg     <= '0;
            neg_reg    <= 1'b0;
            mcand_reg  <= '0;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            rd_out_reg <= '0;
        end else if (mdu.flush) begin
            cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mdu.in_valid) begin
                        op_reg     <= mdu.mdop[1:0];
                        neg_reg    <= neg_in;
                        rd_out_reg <= mdu.rd_in;
                        cnt_reg    <= '0;
                        mcand_reg  <= mdu.mdop[2] ? abs_b : abs_a;
                        prod_reg   <= {{W{1'b0}}, (mdu.mdop[2] ? abs_a : abs_b)};
                        if (special)
                            result_reg <= special_res;
`ifdef PAK_RV_MDU_FAST_MUL_EN
                        else if (!mdu.mdop[2])
                            result_reg <= fast_res;
`endif
                    end
                end
                MUL: begin
                    prod_reg <= mul_step;
                    cnt_reg  <= cnt_reg + CW'(1);
                    if (last_iter)
                        result_reg <= mul_res;
                end
                DIV: begin
                    prod_reg <= div_step;
                    cnt_reg  <= cnt_reg + CW'(1);
                    if (last_iter)
                        result_reg <= div_res;
                end
                default: ;
            endcase
        end
    end

    assign mdu.in_ready  = (state_reg == IDLE);
    assign mdu.busy      = (state_reg != IDLE);
    assign mdu.out_valid = (state_reg == DONE);
    assign mdu.result    = result_reg;
    assign mdu.rd_out    = rd_out_reg;
endmodule

// File: tb/tb_ex_mdu_stage.sv
// Directed vector bench for ex_mdu_stage: table of operations plus hand-written
// sequences for reset, back-pressure and flush corner cases.
module tb_ex_mdu_stage;
    localparam int W = 32;
    localparam int R = 5;
`ifdef PAK_RV_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;
    localparam int TIMEOUT = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ex_mdu_stage_if #(.DATA_WIDTH(W), .RD_WIDTH(R)) mdu_if ();

    ex_mdu_stage #(.DATA_WIDTH(W), .RD_WIDTH(R)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .mdu  (mdu_if)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [R-1:0] rd;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [R-1:0] rd);
        mdu_if.in_valid = 1'b1;
        mdu_if.mdop     = op;
        mdu_if.opr_a    = a;
        mdu_if.opr_b    = b;
        mdu_if.rd_in    = rd;
    endtask

    // Called on the negedge after the accepting posedge; returns the cycle out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!mdu_if.out_valid && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        @(negedge clk);
        check($sformatf("v%0d_in_ready", idx), 64'(mdu_if.in_ready), 64'd1);
        drive_req(v.op, v.a, v.b, v.rd);
        @(negedge clk);
        mdu_if.in_valid = 1'b0;
        wait_valid(lat);
        check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
        check($sformatf("v%0d_result", idx), 64'(mdu_if.result), 64'(v.exp));
        check($sformatf("v%0d_rd_out", idx), 64'(mdu_if.rd_out), 64'(v.rd));
        mdu_if.out_ready = 1'b1;
        @(negedge clk);
        mdu_if.out_ready = 1'b0;
        check($sformatf("v%0d_idle_after", idx), {62'd0, mdu_if.in_ready, mdu_if.out_valid}, 64'b10);
    endtask

    initial begin
        int lat;
        int ov_seen;

        vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000003, 5'd1,  32'hFFFFFFFD, MUL_LAT};
        vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'h00000003, 5'd2,  32'h00000002, MUL_LAT};
        vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'h00000003, 5'd3,  32'hFFFFFFFF, MUL_LAT};
        vecs[3]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd4,  32'h80000000, MUL_LAT};
        vecs[4]  = '{3'd1, 32'h80000000, 32'h80000000, 5'd5,  32'h40000000, MUL_LAT};
        vecs[5]  = '{3'd0, 32'h12345678, 32'h00000010, 5'd6,  32'h23456780, MUL_LAT};
        vecs[6]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd7,  32'hFFFFFFFD, DIV_LAT};
        vecs[7]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd8,  32'hFFFFFFFF, DIV_LAT};
        vecs[8]  = '{3'd5, 32'h00000007, 32'h00000002, 5'd9,  32'h00000003, DIV_LAT};
        vecs[9]  = '{3'd7, 32'h00000007, 32'h00000002, 5'd10, 32'h00000001, DIV_LAT};
        vecs[10] = '{3'd5, 32'hFFFFFFF9, 32'h00000002, 5'd11, 32'h7FFFFFFC, DIV_LAT};
        vecs[11] = '{3'd4, 32'h00000007, 32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, DIV_LAT};
        vecs[12] = '{3'd6, 32'h00000007, 32'hFFFFFFFE, 5'd13, 32'h00000001, DIV_LAT};
        vecs[13] = '{3'd4, 32'h12345678, 32'h00000000, 5'd14, 32'hFFFFFFFF, 1};
        vecs[14] = '{3'd7, 32'h12345678, 32'h00000000, 5'd15, 32'h12345678, 1};
        vecs[15] = '{3'd6, 32'h12345678, 32'h00000000, 5'd16, 32'h12345678, 1};
        vecs[16] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1};
        vecs[17] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h00000000, 1};
        vecs[18] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h00000000, DIV_LAT};

        mdu_if.in_valid  = 1'b0;
        mdu_if.mdop      = 3'd0;
        mdu_if.opr_a     = '0;
        mdu_if.opr_b     = '0;
        mdu_if.rd_in     = '0;
        mdu_if.flush     = 1'b0;
        mdu_if.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(mdu_if.out_valid), 64'd0);
        check("rst_busy", 64'(mdu_if.busy), 64'd0);
        check("rst_result", 64'(mdu_if.result), 64'd0);
        check("rst_rd_out", 64'(mdu_if.rd_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(mdu_if.in_ready), 64'd1);

        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i]);
            $display("vec %0d op=%0d a=%h b=%h -> result=%h rd=%0d", i, vecs[i].op,
                     vecs[i].a, vecs[i].b, mdu_if.result, mdu_if.rd_out);
        end

        // Back-pressure in DONE: outputs held, new request ignored
        @(negedge clk);
        drive_req(3'd5, 32'd100, 32'd7, 5'd9);
        @(negedge clk);
        mdu_if.in_valid = 1'b0;
        wait_valid(lat);
        check("hold_latency", 64'(lat), 64'(DIV_LAT));
        for (int k = 0; k < 5; k++) begin
            drive_req(3'd0, 32'd1, 32'd1, 5'd3);
            @(negedge clk);
            check($sformatf("hold%0d_result", k), 64'(mdu_if.result), 64'd14);
            check($sformatf("hold%0d_rd_out", k), 64'(mdu_if.rd_out), 64'd9);
            check($sformatf("hold%0d_flags", k),
                  {61'd0, mdu_if.out_valid, mdu_if.in_ready, mdu_if.busy}, 64'b101);
        end
        mdu_if.in_valid  = 1'b0;
        mdu_if.out_ready = 1'b1;
        @(negedge clk);
        mdu_if.out_ready = 1'b0;
        check("hold_release", {61'd0, mdu_if.out_valid, mdu_if.in_ready, mdu_if.busy}, 64'b010);
        @(negedge clk);
        check("hold_no_launch", {62'd0, mdu_if.out_valid, mdu_if.busy}, 64'b00);
        $display("hold sequence: result=14 rd=9 released");

        // Flush at multiply iteration 4 together with a new request
        drive_req(3'd0, 32'd5, 32'd6, 5'd1);
        @(negedge clk);
        mdu_if.in_valid = 1'b0;
        ov_seen = 0;
        for (int k = 0; k < 3; k++) begin
            if (mdu_if.out_valid) ov_seen++;
            @(negedge clk);
        end
`ifndef PAK_RV_MDU_FAST_MUL_EN
        check("flush_no_early_valid", 64'(ov_seen), 64'd0);
`endif
        mdu_if.flush = 1'b1;
        drive_req(3'd5, 32'd20, 32'd4, 5'd2);
        @(negedge clk);
        mdu_if.flush = 1'b0;
        check("flush_idle", {61'd0, mdu_if.out_valid, mdu_if.in_ready, mdu_if.busy}, 64'b010);
        @(negedge clk);
        mdu_if.in_valid = 1'b0;
        check("flush_reaccept_busy", 64'(mdu_if.busy), 64'd1);
        wait_valid(lat);
        check("flush_new_latency", 64'(lat), 64'(DIV_LAT));
        check("flush_new_result", 64'(mdu_if.result), 64'd5);
        check("flush_new_rd_out", 64'(mdu_if.rd_out), 64'd2);
        mdu_if.out_ready = 1'b1;
        @(negedge clk);
        mdu_if.out_ready = 1'b0;
        $display("flush sequence: new op result=%h rd=%0d", mdu_if.result, mdu_if.rd_out);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        drive_req(3'd4, 32'd1000, 32'd3, 5'd7);
        @(negedge clk);
        mdu_if.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("middiv_busy_before", 64'(mdu_if.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("middiv_rst_flags", {61'd0, mdu_if.out_valid, mdu_if.in_ready, mdu_if.busy}, 64'b010);
        @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mdu_if.out_valid) ov_seen++;
        end
        check("middiv_no_result", 64'(ov_seen), 64'd0);
        check("middiv_in_ready", 64'(mdu_if.in_ready), 64'd1);
        $display("reset mid-divide: out_valid cycles after release=%0d", ov_seen);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
